// File: rtl/cond_control_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cond_control_pipe: D-stage control decode, D->E control register, E-stage  |
// | condition check with local NZCV flags; CCP_MULTICYCLE_MUL_EN holds MULs.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cond_control_pipe #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = $clog2(MUL_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] CondD,
  input  logic [1:0] OpD,
  input  logic [5:0] FunctD,
  input  logic [3:0] RdD,
  input  logic       FlushE,
  input  logic [3:0] ALUFlagsE,
  output logic [1:0] RegSrcD,
  output logic [1:0] ImmSrcD,
  output logic       ALUSrcE,
  output logic       MemToRegE,
  output logic [3:0] ALUControlE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       PCSrcE,
  output logic       CondExE,
  output logic [3:0] FlagsQ,
  output logic       BusyE
);

  localparam logic [3:0] c_ALU_ADD = 4'b0000;
  localparam logic [3:0] c_ALU_SUB = 4'b0001;
  localparam logic [3:0] c_ALU_MUL = 4'b0010;
  localparam logic [3:0] c_ALU_ORR = 4'b0011;
  localparam logic [3:0] c_ALU_MOV = 4'b0110;

  localparam logic [3:0] c_CMD_ADD = 4'b0100;
  localparam logic [3:0] c_CMD_SUB = 4'b0010;
  localparam logic [3:0] c_CMD_MUL = 4'b0000;
  localparam logic [3:0] c_CMD_ORR = 4'b1100;
  localparam logic [3:0] c_CMD_MOV = 4'b1101;
  localparam logic [3:0] c_CMD_CMP = 4'b1010;

  // A cleared word is a bubble: valid=0 keeps CondExE and every enable low.
  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       pc_src;
    logic       no_write;
    logic [1:0] flag_write;
    logic [3:0] alu_ctl;
  } ctrl_t;

  ctrl_t      dec_w;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic [3:0] flags_d;
  logic [3:0] flags_q;
  logic [1:0] regsrc_w;
  logic [1:0] immsrc_w;
  logic       dp_ok_w;
  logic       cv_cmd_w;
  logic       set_flg_w;
  logic       branch_w;
  logic       cond_pass_w;
  logic       flg_n_w;
  logic       flg_z_w;
  logic       flg_c_w;
  logic       flg_v_w;
  logic       busy_w;

  always_comb begin
    dec_w         = '0;
    regsrc_w      = 2'b00;
    immsrc_w      = 2'b00;
    dp_ok_w       = 1'b0;
    cv_cmd_w      = 1'b0;
    set_flg_w     = FunctD[0];
    branch_w      = 1'b0;
    dec_w.valid   = 1'b1;
    dec_w.cond    = CondD;
    dec_w.alu_ctl = c_ALU_ADD;
    case (OpD)
      2'b00: begin
        dp_ok_w = 1'b1;
        case (FunctD[4:1])
          c_CMD_ADD: begin
            dec_w.alu_ctl = c_ALU_ADD;
            cv_cmd_w      = 1'b1;
          end
          c_CMD_SUB: begin
            dec_w.alu_ctl = c_ALU_SUB;
            cv_cmd_w      = 1'b1;
          end
          c_CMD_MUL: dec_w.alu_ctl = c_ALU_MUL;
          c_CMD_ORR: dec_w.alu_ctl = c_ALU_ORR;
          c_CMD_MOV: begin
            dec_w.alu_ctl = c_ALU_MOV;
            cv_cmd_w      = 1'b1;
          end
          c_CMD_CMP: begin
            dec_w.alu_ctl  = c_ALU_SUB;
            dec_w.no_write = 1'b1;
            cv_cmd_w       = 1'b1;
            set_flg_w      = 1'b1;
          end
          default: dp_ok_w = 1'b0;
        endcase
        if (dp_ok_w) begin
          dec_w.alu_src    = FunctD[5];
          dec_w.reg_write  = 1'b1;
          dec_w.flag_write = {set_flg_w, set_flg_w & cv_cmd_w};
        end
      end
      2'b01: begin
        immsrc_w      = 2'b01;
        dec_w.alu_src = 1'b1;
        if (FunctD[0]) begin
          dec_w.mem_to_reg = 1'b1;
          dec_w.reg_write  = 1'b1;
        end else begin
          regsrc_w        = 2'b10;
          dec_w.mem_write = 1'b1;
        end
      end
      2'b10: begin
        regsrc_w      = 2'b01;
        immsrc_w      = 2'b10;
        dec_w.alu_src = 1'b1;
        branch_w      = 1'b1;
      end
      default: ;
    endcase
    dec_w.pc_src = ((RdD == 4'hF) & dec_w.reg_write) | branch_w;
  end

  assign RegSrcD = regsrc_w;
  assign ImmSrcD = immsrc_w;

  assign {flg_n_w, flg_z_w, flg_c_w, flg_v_w} = flags_q;

  always_comb begin
    cond_pass_w = 1'b0;
    case (ctrl_q.cond)
      4'b0000: cond_pass_w = flg_z_w;
      4'b0001: cond_pass_w = ~flg_z_w;
      4'b0010: cond_pass_w = flg_c_w;
      4'b0011: cond_pass_w = ~flg_c_w;
      4'b0100: cond_pass_w = flg_n_w;
      4'b0101: cond_pass_w = ~flg_n_w;
      4'b1010: cond_pass_w = (flg_n_w == flg_v_w);
      4'b1011: cond_pass_w = (flg_n_w != flg_v_w);
      4'b1100: cond_pass_w = ~flg_z_w & (flg_n_w == flg_v_w);
      4'b1101: cond_pass_w = flg_z_w | (flg_n_w != flg_v_w);
      4'b1110: cond_pass_w = 1'b1;
      default: cond_pass_w = 1'b0;
    endcase
  end

  assign CondExE = ctrl_q.valid & cond_pass_w;

`ifdef CCP_MULTICYCLE_MUL_EN
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_t;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_enter_w;

  assign mul_enter_w = (state_q == ST_IDLE) & (ctrl_q.alu_ctl == c_ALU_MUL) & CondExE;
  assign busy_w      = ((state_q == ST_MUL) | mul_enter_w) & (cnt_q != c_CNT_LAST);

  // The last MUL cycle is not busy, so its writes fire before returning to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if ((state_q == ST_MUL) || mul_enter_w) begin
      if (cnt_q == c_CNT_LAST) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= ST_MUL;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign busy_w = 1'b0;

  if ((MUL_CYCLES < 2) || (MUL_CYCLES > 16) || (CNT_W < 1)) begin : g_mul_cfg_ignored
  end
`endif

  assign BusyE = busy_w;

  always_comb begin
    ctrl_d = dec_w;
    if (busy_w) begin
      ctrl_d = ctrl_q;
    end else if (FlushE) begin
      ctrl_d = '0;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (CondExE & ~busy_w) begin
      if (ctrl_q.flag_write[1]) flags_d[3:2] = ALUFlagsE[3:2];
      if (ctrl_q.flag_write[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      flags_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  assign FlagsQ      = flags_q;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUControlE = ctrl_q.alu_ctl;
  assign MemToRegE   = ctrl_q.mem_to_reg & CondExE;
  assign RegWriteE   = ctrl_q.reg_write & CondExE & ~ctrl_q.no_write & ~busy_w;
  assign MemWriteE   = ctrl_q.mem_write & CondExE & ~busy_w;
  assign PCSrcE      = ctrl_q.pc_src & CondExE & ~busy_w;

endmodule
`default_nettype wire

// File: tb/tb_cond_control_pipe.sv
`default_nettype none
// Bench for cond_control_pipe: directed scenarios then random traffic against a behavioural model.
module tb_cond_control_pipe;

  localparam int c_MUL_CYCLES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] CondD;
  logic [1:0] OpD;
  logic [5:0] FunctD;
  logic [3:0] RdD;
  logic       FlushE;
  logic [3:0] ALUFlagsE;
  logic [1:0] RegSrcD;
  logic [1:0] ImmSrcD;
  logic       ALUSrcE;
  logic       MemToRegE;
  logic [3:0] ALUControlE;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       PCSrcE;
  logic       CondExE;
  logic [3:0] FlagsQ;
  logic       BusyE;

  cond_control_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .CondD      (CondD),
    .OpD        (OpD),
    .FunctD     (FunctD),
    .RdD        (RdD),
    .FlushE     (FlushE),
    .ALUFlagsE  (ALUFlagsE),
    .RegSrcD    (RegSrcD),
    .ImmSrcD    (ImmSrcD),
    .ALUSrcE    (ALUSrcE),
    .MemToRegE  (MemToRegE),
    .ALUControlE(ALUControlE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .PCSrcE     (PCSrcE),
    .CondExE    (CondExE),
    .FlagsQ     (FlagsQ),
    .BusyE      (BusyE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       alusrc;
    logic       m2r;
    logic       rw;
    logic       mw;
    logic       br;
    logic       nowr;
    logic [1:0] fw;
    logic [3:0] alu;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
  } instr_t;

  int n_chk  = 0;
  int n_fail = 0;

  instr_t     m_e;
  logic [3:0] m_flags;
  int         m_age;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control table straight from the instruction-class descriptions.
  function automatic dec_t decode(input logic [1:0] op, input logic [5:0] f);
    dec_t d;
    logic s;
    d = '0;
    s = f[0];
    case (op)
      2'b00: begin
        case (f[4:1])
          4'b0100: d.alu = 4'b0000;
          4'b0010: d.alu = 4'b0001;
          4'b0000: d.alu = 4'b0010;
          4'b1100: d.alu = 4'b0011;
          4'b1101: d.alu = 4'b0110;
          4'b1010: begin d.alu = 4'b0001; d.nowr = 1'b1; s = 1'b1; end
          default: return '0;
        endcase
        d.alusrc = f[5];
        d.rw     = 1'b1;
        d.fw[1]  = s;
        d.fw[0]  = s && (f[4:1] inside {4'b0100, 4'b0010, 4'b1101, 4'b1010});
      end
      2'b01: begin
        if (f[0]) {d.regsrc, d.immsrc, d.alusrc, d.m2r, d.rw, d.mw, d.br} = {2'b00, 2'b01, 5'b11100};
        else      {d.regsrc, d.immsrc, d.alusrc, d.m2r, d.rw, d.mw, d.br} = {2'b10, 2'b01, 5'b10010};
      end
      2'b10: {d.regsrc, d.immsrc, d.alusrc, d.m2r, d.rw, d.mw, d.br} = {2'b01, 2'b10, 5'b10001};
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic dec_t m_dec();
    return m_e.valid ? decode(m_e.op, m_e.funct) : '0;
  endfunction

  function automatic logic m_condex();
    return m_e.valid && cond_ok(m_e.cond, m_flags);
  endfunction

  function automatic logic m_busy();
`ifdef CCP_MULTICYCLE_MUL_EN
    return m_condex() && (m_dec().alu == 4'b0010) && (m_age < c_MUL_CYCLES - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [10:0] obs_e();
    return {ALUSrcE, MemToRegE, ALUControlE, RegWriteE, MemWriteE, PCSrcE, CondExE, BusyE};
  endfunction

  function automatic logic [10:0] exp_e();
    dec_t d;
    logic cx, bz, pcs;
    d   = m_dec();
    cx  = m_condex();
    bz  = m_busy();
    pcs = ((m_e.rd == 4'hF) && d.rw) || d.br;
    return {d.alusrc, d.m2r & cx, d.alu, d.rw & cx & ~d.nowr & ~bz,
            d.mw & cx & ~bz, pcs & cx & ~bz, cx, bz};
  endfunction

  task automatic model_reset();
    m_e     = '0;
    m_flags = 4'b0000;
    m_age   = 0;
  endtask

  // Drive one D-stage instruction, check the current E state, then advance one edge.
  task automatic step(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                      input logic [3:0] cond, input logic flush, input logic [3:0] flg);
    dec_t       d, dd;
    logic       cx, bz;
    logic [3:0] nf;
    instr_t     ne;
    int         na;
    OpD = op; FunctD = funct; RdD = rd; CondD = cond; FlushE = flush; ALUFlagsE = flg;
    #1;
    dd = decode(op, funct);
    chk("e_ctrl", 16'(obs_e()), 16'(exp_e()));
    chk("flags", 16'(FlagsQ), 16'(m_flags));
    chk("d_src", 16'({RegSrcD, ImmSrcD}), 16'({dd.regsrc, dd.immsrc}));
    d  = m_dec();
    cx = m_condex();
    bz = m_busy();
    nf = m_flags;
    if (cx && !bz) begin
      if (d.fw[1]) nf[3:2] = flg[3:2];
      if (d.fw[0]) nf[1:0] = flg[1:0];
    end
    if (bz) begin
      ne = m_e;
      na = m_age + 1;
    end else begin
      na = 0;
      ne = flush ? '0 : {1'b1, op, funct, rd, cond};
    end
    @(posedge clk);
    #1;
    m_e = ne; m_flags = nf; m_age = na;
  endtask

  initial begin
    logic [3:0] cmds [6];
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] cd;
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};

    reset = 1'b0; OpD = '0; FunctD = '0; RdD = '0; CondD = '0; FlushE = 1'b0; ALUFlagsE = '0;
    model_reset();
    #2;
    chk("rst0_e", 16'(obs_e()), 16'd0);
    chk("rst0_flags", 16'(FlagsQ), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // AL ADDS, flags captured one edge later
    step(2'b00, 6'b101001, 4'd2, 4'b1110, 1'b0, 4'b0000);
    chk("t2_regwrite", 16'(RegWriteE), 16'd1);
    chk("t2_aluctl", 16'(ALUControlE), 16'd0);
    step(2'b00, 6'b101001, 4'd2, 4'b1110, 1'b0, 4'b0110);
    chk("t2_flags", 16'(FlagsQ), 16'h6);
    // BNE with Z set fails, BEQ redirects
    step(2'b10, 6'b000000, 4'd0, 4'b0001, 1'b0, 4'b0100);
    chk("t3_flags", 16'(FlagsQ), 16'h4);
    chk("t3_bne_pcsrc", 16'(PCSrcE), 16'd0);
    chk("t3_bne_condex", 16'(CondExE), 16'd0);
    step(2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0, 4'b1111);
    chk("t3_beq_pcsrc", 16'(PCSrcE), 16'd1);
    // CMP writes no register; MOVEQ after it sees Z=0
    step(2'b00, 6'b010101, 4'd0, 4'b1110, 1'b0, 4'b0000);
    chk("t4_cmp_regwrite", 16'(RegWriteE), 16'd0);
    step(2'b00, 6'b111010, 4'd4, 4'b0000, 1'b0, 4'b1000);
    chk("t4_flags", 16'(FlagsQ), 16'h8);
    chk("t4_moveq_regwrite", 16'(RegWriteE), 16'd0);
    // Flushed LDR becomes a bubble; Op=11 is a NOP
    step(2'b01, 6'b011001, 4'd5, 4'b1110, 1'b1, 4'b0000);
    chk("t6_flush_e", 16'({RegWriteE, MemToRegE, ALUControlE}), 16'd0);
    step(2'b11, 6'b111111, 4'd15, 4'b1110, 1'b0, 4'b0000);
    chk("t6_nop_en", 16'({RegWriteE, MemWriteE, PCSrcE, MemToRegE}), 16'd0);
    step(2'b01, 6'b011001, 4'd5, 4'b1110, 1'b0, 4'b0000);
    chk("t6_ldr_m2r", 16'(MemToRegE), 16'd1);
    step(2'b00, 6'b001000, 4'd1, 4'b1110, 1'b0, 4'b0000);

    // Asynchronous reset with ADD in E
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t1_rst_e", 16'(obs_e()), 16'd0);
    chk("t1_rst_flags", 16'(FlagsQ), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    step(2'b00, 6'b001000, 4'd1, 4'b1110, 1'b0, 4'b0000);
    chk("t1_first_decode", 16'({RegWriteE, ALUControlE}), 16'h10);

    // AL MUL occupancy
    step(2'b00, 6'b000000, 4'd3, 4'b1110, 1'b0, 4'b0000);
`ifdef CCP_MULTICYCLE_MUL_EN
    chk("t5_c1", 16'({BusyE, RegWriteE}), 16'b10);
    step(2'b00, 6'b001000, 4'd1, 4'b1110, 1'b1, 4'b0000);
    chk("t5_c2", 16'({BusyE, RegWriteE}), 16'b10);
    step(2'b00, 6'b001000, 4'd1, 4'b1110, 1'b0, 4'b0000);
    chk("t5_c3", 16'({BusyE, RegWriteE}), 16'b01);
`else
    chk("t5_single", 16'({BusyE, RegWriteE}), 16'b01);
`endif
    step(2'b00, 6'b001000, 4'd1, 4'b1110, 1'b0, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) != 0) fn[4:1] = cmds[$urandom_range(0, 5)];
      cd = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom);
      step(op, fn, 4'($urandom), cd, ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
